// File: rtl/hdc_pkg.sv
// Shared HDC constants, hypervector type and the spatial encoder state encoding.
// Channel counts are the per-modality NUM_CHANNEL values used at instantiation.
package hdc_pkg;
  localparam int HV_DIMENSION    = 2000;
  localparam int GSR_NUM_CHANNEL = 1;
  localparam int ECG_NUM_CHANNEL = 3;
  localparam int EEG_NUM_CHANNEL = 32;

  typedef logic [HV_DIMENSION-1:0] hv_t;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} enc_state_e;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/spatial_encoder_bit_counter_array.sv
// One CW-bit counter per hypervector dimension plus the majority compare.
// The majority is taken on next-state counts so the frame result is ready on the last beat.
module bit_counter_array #(
  parameter int HV_DIMENSION = 8,
  parameter int CW           = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic                    clear_i,
  input  logic [HV_DIMENSION-1:0] bits_i,
  input  logic [CW-1:0]           act_i,
  output logic [HV_DIMENSION-1:0] maj_o
);
  for (genvar g = 0; g < HV_DIMENSION; g++) begin : g_dim
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i)     cnt_d = '0;
      else if (load_i) cnt_d = CW'(bits_i[g]);
      else if (add_i)  cnt_d = cnt_q + CW'(bits_i[g]);
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    // 2*cnt > act in CW+1 bits; ties and empty frames yield 0.
    assign maj_o[g] = {cnt_d, 1'b0} > {1'b0, act_i};
  end
endmodule

// File: rtl/spatial_encoder.sv
// Spatial encoder: binds im/projm per channel beat, bundles a frame by majority.
// FSM IDLE -> ACCUM -> HOLD; the result is held until the consumer takes it.
module spatial_encoder #(
  parameter int NUM_CHANNEL  = 32,
  parameter int HV_DIMENSION = hdc_pkg::HV_DIMENSION
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [HV_DIMENSION-1:0]            din_im,
  input  logic [HV_DIMENSION-1:0]            din_projm,
  input  logic                               din_valid,
  output logic                               din_ready,
  output logic [HV_DIMENSION-1:0]            dout_hv,
  output logic [$clog2(NUM_CHANNEL+1)-1:0]   dout_active,
  output logic                               dout_valid,
  input  logic                               dout_ready
);
  import hdc_pkg::*;

  localparam int            CW        = cnt_width(NUM_CHANNEL);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_CHANNEL - 1);

  enc_state_e               state_q;
  logic [CW-1:0]            beat_q, act_q, act_d, dout_active_q;
  logic                     din_ready_q, dout_valid_q;
  logic [HV_DIMENSION-1:0]  dout_hv_q, bits, maj;
  logic                     fire, active, first, last, add, clear;

  assign fire   = din_valid && din_ready_q;
  assign active = |din_projm;
  // Inactive beats contribute nothing, so they load/add zeros.
  assign bits   = active ? (din_im ^ din_projm) : '0;
  assign first  = fire && (state_q == IDLE);
  assign add    = fire && (state_q == ACCUM);
  assign last   = fire && (((state_q == IDLE) && (NUM_CHANNEL == 1)) ||
                           ((state_q == ACCUM) && (beat_q == LAST_BEAT)));
  assign clear  = (state_q == HOLD) && dout_ready;
  assign act_d  = first ? CW'(active) : act_q + CW'(active);

  bit_counter_array #(
    .HV_DIMENSION (HV_DIMENSION),
    .CW           (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (first),
    .add_i   (add),
    .clear_i (clear),
    .bits_i  (bits),
    .act_i   (act_d),
    .maj_o   (maj)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      act_q         <= '0;
      din_ready_q   <= 1'b1;
      dout_valid_q  <= 1'b0;
      dout_hv_q     <= '0;
      dout_active_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          beat_q  <= CW'(1);
          act_q   <= act_d;
          state_q <= ACCUM;
        end
        ACCUM: if (fire) begin
          beat_q <= beat_q + CW'(1);
          act_q  <= act_d;
        end
        HOLD: if (dout_ready) begin
          state_q      <= IDLE;
          beat_q       <= '0;
          din_ready_q  <= 1'b1;
          dout_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (last) begin
        state_q       <= HOLD;
        din_ready_q   <= 1'b0;
        dout_valid_q  <= 1'b1;
        dout_hv_q     <= maj;
        dout_active_q <= act_d;
      end
    end
  end

  assign din_ready   = din_ready_q;
  assign dout_valid  = dout_valid_q;
  assign dout_hv     = dout_hv_q;
  assign dout_active = dout_active_q;
endmodule

// File: tb/tb_spatial_encoder.sv
// Directed and random frames against a counting majority model, for NUM_CHANNEL=3 and =1.
module tb_spatial_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din_im, din_projm, dout_hv;
  logic       din_valid, din_ready, dout_valid, dout_ready;
  logic [1:0] dout_active;

  logic [7:0] a_im, a_pm, a_hv;
  logic       a_valid, a_ready, a_ovalid, a_oready;
  logic [0:0] a_active;

  int nvec = 0;
  int nerr = 0;

  spatial_encoder #(.NUM_CHANNEL(3), .HV_DIMENSION(8)) dut (
    .clk(clk), .rst(rst), .din_im(din_im), .din_projm(din_projm),
    .din_valid(din_valid), .din_ready(din_ready), .dout_hv(dout_hv),
    .dout_active(dout_active), .dout_valid(dout_valid), .dout_ready(dout_ready));

  spatial_encoder #(.NUM_CHANNEL(1), .HV_DIMENSION(8)) dut1 (
    .clk(clk), .rst(rst), .din_im(a_im), .din_projm(a_pm),
    .din_valid(a_valid), .din_ready(a_ready), .dout_hv(a_hv),
    .dout_active(a_active), .dout_valid(a_ovalid), .dout_ready(a_oready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count set bound bits over active channels, majority strictly above half.
  task automatic ref_model(input logic [7:0] im[], input logic [7:0] pm[],
                           output logic [7:0] hv, output int act);
    int cnt[8];
    act = 0;
    foreach (cnt[d]) cnt[d] = 0;
    foreach (im[i]) if (pm[i] != 0) begin
      logic [7:0] b;
      b = im[i] ^ pm[i];
      act++;
      for (int d = 0; d < 8; d++) if (b[d]) cnt[d]++;
    end
    for (int d = 0; d < 8; d++) hv[d] = (2 * cnt[d] > act);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Stream a 3-beat frame (optional idle gaps) and check the held result.
  task automatic frame3(input string tag, input logic [7:0] im[], input logic [7:0] pm[],
                        input bit gaps);
    logic [7:0] hv;
    int act;
    ref_model(im, pm, hv, act);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".din_ready"}, din_ready, 1);
      din_valid = 1'b1; din_im = im[i]; din_projm = pm[i];
      step();
      din_valid = 1'b0; din_im = 8'($urandom); din_projm = 8'($urandom);
      if (i < 2) begin
        chk({tag, ".early_valid"}, dout_valid, 0);
        if (gaps) repeat ($urandom_range(0, 3)) step();
      end
    end
    chk({tag, ".dout_valid"}, dout_valid, 1);
    chk({tag, ".dout_hv"}, dout_hv, hv);
    chk({tag, ".dout_active"}, dout_active, act);
    chk({tag, ".hold_ready"}, din_ready, 0);
  endtask

  task automatic take3(input string tag);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk({tag, ".post_valid"}, dout_valid, 0);
    chk({tag, ".post_ready"}, din_ready, 1);
  endtask

  initial begin
    logic [7:0] im[], pm[], im1[], pm1[], hv;
    int act;
    im = new[3]; pm = new[3]; im1 = new[1]; pm1 = new[1];
    rst = 1'b1; din_valid = 0; din_im = 0; din_projm = 0; dout_ready = 0;
    a_valid = 0; a_im = 0; a_pm = 0; a_oready = 0;
    step(); step();
    rst = 1'b0;
    chk("rst.din_ready", din_ready, 1);
    chk("rst.dout_valid", dout_valid, 0);
    chk("rst.dout_hv", dout_hv, 0);
    chk("rst.dout_active", dout_active, 0);
    chk("rst1.dout_valid", a_ovalid, 0);

    // Basic majority: bound 0xFF, 0x81, 0xFE.
    im = '{8'h0F, 8'h00, 8'hFF}; pm = '{8'hF0, 8'h81, 8'h01};
    frame3("basic", im, pm, 0);
    chk("basic.hv_const", dout_hv, 8'hFF);
    take3("basic");

    // Inactive first channel, tie on two active channels.
    im = '{8'h3C, 8'h0F, 8'h00}; pm = '{8'h00, 8'h03, 8'hF0};
    frame3("tie", im, pm, 0);
    chk("tie.hv_const", dout_hv, 8'h00);
    chk("tie.act_const", dout_active, 2);
    take3("tie");

    im = '{8'hAA, 8'h55, 8'hFF}; pm = '{8'h00, 8'h00, 8'h00};
    frame3("inactive", im, pm, 0);
    chk("inactive.act_const", dout_active, 0);
    take3("inactive");

    // Backpressure with a din_valid pulse during HOLD.
    im = '{8'h0F, 8'h00, 8'hFF}; pm = '{8'hF0, 8'h81, 8'h01};
    frame3("bp", im, pm, 0);
    for (int c = 0; c < 5; c++) begin
      din_valid = (c == 2); din_im = 8'hFF; din_projm = 8'hFF;
      step();
      chk("bp.valid", dout_valid, 1);
      chk("bp.hv", dout_hv, 8'hFF);
      chk("bp.active", dout_active, 3);
      chk("bp.din_ready", din_ready, 0);
    end
    din_valid = 0;
    take3("bp");
    foreach (im[i]) begin im[i] = 8'($urandom); pm[i] = 8'($urandom | 1); end
    frame3("bp.next", im, pm, 0);
    take3("bp.next");

    // Random frames, some with idle gaps and inactive channels.
    for (int f = 0; f < 25; f++) begin
      foreach (im[i]) begin
        im[i] = 8'($urandom);
        pm[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      frame3("rand", im, pm, f[0]);
      if (f % 4 == 3) begin
        dout_ready = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        chk("rand.stall_valid", dout_valid, 1);
      end
      take3("rand");
    end

    // Reset mid-frame discards the partial counts.
    for (int i = 0; i < 2; i++) begin
      din_valid = 1; din_im = 8'hF0; din_projm = 8'h0F;
      step();
    end
    din_valid = 0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.din_ready", din_ready, 1);
    chk("midrst.dout_valid", dout_valid, 0);
    im = '{8'h01, 8'h01, 8'h01}; pm = '{8'h02, 8'h02, 8'h02};
    frame3("midrst", im, pm, 0);
    chk("midrst.hv_const", dout_hv, 8'h03);
    chk("midrst.act_const", dout_active, 3);
    take3("midrst");

    // NUM_CHANNEL=1 instance.
    for (int f = 0; f < 6; f++) begin
      im1[0] = (f == 0) ? 8'hA0 : 8'($urandom);
      pm1[0] = (f == 0) ? 8'h05 : ((f == 1) ? 8'h00 : 8'($urandom));
      ref_model(im1, pm1, hv, act);
      chk("nc1.din_ready", a_ready, 1);
      a_valid = 1; a_im = im1[0]; a_pm = pm1[0];
      step();
      a_valid = 0;
      chk("nc1.dout_valid", a_ovalid, 1);
      chk("nc1.dout_hv", a_hv, hv);
      chk("nc1.dout_active", a_active, act);
      if (f == 0) chk("nc1.hv_const", a_hv, 8'hA5);
      a_oready = 1;
      step();
      a_oready = 0;
      chk("nc1.post_valid", a_ovalid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
